// File: rtl/mem_stage_lsu.sv
// mem_stage_lsu: MEM stage of the 5-stage RV32I pipeline.
// It drives the word-wide data RAM and performs LB/LH/LW/LBU/LHU/SB/SH/SW.
// It also registers the MEM/WB payload.
//
// Optional feature macro: LSU_RAM_BE_EN
//   defined   -> RAM_BE byte-enable port; sub-word stores finish in a single cycle.
//   undefined -> sub-word stores use a 2-cycle read-modify-write and stall EX.
//
// Ports:
//   CLK, RESET_N             clock (posedge) and async active-low reset
//   EX_*                     EX/MEM payload: valid, load/store flags, funct3,
//                            address / ALU result, store data, rd, regwrite
//   STALL                    upstream must hold EX_* this cycle (combinational)
//   RAM_ADDRESS/DATAIN/WE    data RAM request (combinational, same cycle)
//   RAM_BE                   per-byte write enable (LSU_RAM_BE_EN only)
//   RAM_DATAOUT              registered RAM read data, 1-cycle latency
//   WB_VALID/REGWRITE/RD/DATA  registered MEM/WB payload
//   MISALIGN                 1-cycle pulse for a suppressed misaligned access
module mem_stage_lsu #(
    parameter int unsigned ADDR_W = 10,
    parameter int unsigned XLEN   = 32
) (
    input  logic              CLK,
    input  logic              RESET_N,
    input  logic              EX_VALID,
    input  logic              EX_MEMREAD,
    input  logic              EX_MEMWRITE,
    input  logic [2:0]        EX_FUNCT3,
    input  logic [XLEN-1:0]   EX_ADDR,
    input  logic [XLEN-1:0]   EX_WDATA,
    input  logic [4:0]        EX_RD,
    input  logic              EX_REGWRITE,
    output logic              STALL,
    output logic [ADDR_W-1:0] RAM_ADDRESS,
    output logic [XLEN-1:0]   RAM_DATAIN,
    output logic              RAM_WE,
`ifdef LSU_RAM_BE_EN
    output logic [3:0]        RAM_BE,
`endif
    input  logic [XLEN-1:0]   RAM_DATAOUT,
    output logic              WB_VALID,
    output logic              WB_REGWRITE,
    output logic [4:0]        WB_RD,
    output logic [XLEN-1:0]   WB_DATA,
    output logic              MISALIGN
);

    localparam logic [1:0] IDLE      = 2'd0;
    localparam logic [1:0] LOAD_WAIT = 2'd1;
    localparam logic [1:0] RMW_MERGE = 2'd2;

    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;

    // Access size from funct3; undefined encodings fall back to a word access.
    function automatic logic [1:0] acc_size(input logic [2:0] f3, input logic store);
        logic [1:0] sz;
        sz = SZ_W;
        if (store) begin
            if (f3 == 3'b000)      sz = SZ_B;
            else if (f3 == 3'b001) sz = SZ_H;
        end else begin
            if (f3[1:0] == 2'b00)      sz = SZ_B;
            else if (f3[1:0] == 2'b01) sz = SZ_H;
        end
        return sz;
    endfunction

    // Select the addressed lane of a RAM word and sign- or zero-extend it.
    function automatic logic [XLEN-1:0] load_extract(input logic [XLEN-1:0] w,
                                                     input logic [1:0] sz,
                                                     input logic uns,
                                                     input logic [1:0] off);
        logic [7:0]      b;
        logic [15:0]     h;
        logic [XLEN-1:0] r;
        b = 8'(w >> {off, 3'b000});
        h = 16'(w >> {off[1], 4'b0000});
        case (sz)
            SZ_B:    r = uns ? XLEN'(b) : {{(XLEN-8){b[7]}}, b};
            SZ_H:    r = uns ? XLEN'(h) : {{(XLEN-16){h[15]}}, h};
            default: r = w;
        endcase
        return r;
    endfunction

    // Replace the addressed byte/halfword lanes of old with the low store bits.
    function automatic logic [XLEN-1:0] store_merge(input logic [XLEN-1:0] old,
                                                    input logic [XLEN-1:0] wd,
                                                    input logic [1:0] sz,
                                                    input logic [1:0] off);
        logic [XLEN-1:0] mask;
        logic [XLEN-1:0] data;
        case (sz)
            SZ_B: begin
                mask = XLEN'(8'hFF) << {off, 3'b000};
                data = XLEN'(wd[7:0]) << {off, 3'b000};
            end
            SZ_H: begin
                mask = XLEN'(16'hFFFF) << {off[1], 4'b0000};
                data = XLEN'(wd[15:0]) << {off[1], 4'b0000};
            end
            default: begin
                mask = '1;
                data = wd;
            end
        endcase
        return (old & ~mask) | (data & mask);
    endfunction

    logic [1:0]        state, state_nxt;
    logic [1:0]        lat_size;
    logic              lat_uns;
    logic [1:0]        lat_off;
    logic [ADDR_W-1:0] lat_waddr;
    logic [XLEN-1:0]   lat_wdata;
    logic [4:0]        lat_rd;
    logic              lat_regwrite;
    logic              lat_en;

    logic              stall_c, ram_we_c;
    logic              wb_valid_n, wb_regwrite_n, mis_n;
    logic [4:0]        wb_rd_n;
    logic [XLEN-1:0]   wb_data_n;
    logic [1:0]        sz_c;
    logic              misaligned_c;
`ifdef LSU_RAM_BE_EN
    logic [3:0]        ram_be_c;
`endif

    // Decode of the instruction currently presented by EX.
    assign sz_c         = acc_size(EX_FUNCT3, EX_MEMWRITE);
    assign misaligned_c = ((sz_c == SZ_H) && EX_ADDR[0]) ||
                          ((sz_c == SZ_W) && (EX_ADDR[1:0] != 2'b00));

    // Handshake outputs are forced low while reset is asserted.
    assign STALL  = stall_c  & RESET_N;
    assign RAM_WE = ram_we_c & RESET_N;
`ifdef LSU_RAM_BE_EN
    assign RAM_BE = ram_be_c;
`endif

    // Next-state, RAM request and next MEM/WB payload.
    always_comb begin
        state_nxt     = state;
        stall_c       = 1'b0;
        ram_we_c      = 1'b0;
        RAM_ADDRESS   = EX_ADDR[ADDR_W+1:2];
        RAM_DATAIN    = EX_WDATA;
`ifdef LSU_RAM_BE_EN
        ram_be_c      = 4'b1111;
`endif
        wb_valid_n    = 1'b0;
        wb_regwrite_n = 1'b0;
        wb_rd_n       = EX_RD;
        wb_data_n     = EX_ADDR;
        mis_n         = 1'b0;
        lat_en        = 1'b0;

        case (state)
            IDLE: begin
                if (EX_VALID) begin
                    if (EX_MEMREAD || EX_MEMWRITE) begin
                        if (misaligned_c) begin
                            wb_valid_n = 1'b1;
                            mis_n      = 1'b1;
                        end else if (EX_MEMWRITE) begin
                            if (sz_c == SZ_W) begin
                                ram_we_c   = 1'b1;
                                wb_valid_n = 1'b1;
                            end else begin
`ifdef LSU_RAM_BE_EN
                                ram_we_c   = 1'b1;
                                wb_valid_n = 1'b1;
                                if (sz_c == SZ_B) begin
                                    RAM_DATAIN = {4{EX_WDATA[7:0]}};
                                    ram_be_c   = 4'b0001 << EX_ADDR[1:0];
                                end else begin
                                    RAM_DATAIN = {2{EX_WDATA[15:0]}};
                                    ram_be_c   = EX_ADDR[1] ? 4'b1100 : 4'b0011;
                                end
`else
                                stall_c   = 1'b1;
                                lat_en    = 1'b1;
                                state_nxt = RMW_MERGE;
`endif
                            end
                        end else begin
                            stall_c   = 1'b1;
                            lat_en    = 1'b1;
                            state_nxt = LOAD_WAIT;
                        end
                    end else begin
                        wb_valid_n    = 1'b1;
                        wb_regwrite_n = EX_REGWRITE;
                    end
                end
            end
            LOAD_WAIT: begin
                RAM_ADDRESS   = lat_waddr;
                wb_valid_n    = 1'b1;
                wb_regwrite_n = lat_regwrite;
                wb_rd_n       = lat_rd;
                wb_data_n     = load_extract(RAM_DATAOUT, lat_size, lat_uns, lat_off);
                state_nxt     = IDLE;
            end
            RMW_MERGE: begin
                RAM_ADDRESS = lat_waddr;
                RAM_DATAIN  = store_merge(RAM_DATAOUT, lat_wdata, lat_size, lat_off);
                ram_we_c    = 1'b1;
                wb_valid_n  = 1'b1;
                state_nxt   = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State, latched request and MEM/WB registers.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state        <= IDLE;
            WB_VALID     <= 1'b0;
            WB_REGWRITE  <= 1'b0;
            WB_RD        <= '0;
            WB_DATA      <= '0;
            MISALIGN     <= 1'b0;
            lat_size     <= SZ_W;
            lat_uns      <= 1'b0;
            lat_off      <= '0;
            lat_waddr    <= '0;
            lat_wdata    <= '0;
            lat_rd       <= '0;
            lat_regwrite <= 1'b0;
        end else begin
            state       <= state_nxt;
            WB_VALID    <= wb_valid_n;
            WB_REGWRITE <= wb_regwrite_n;
            WB_RD       <= wb_rd_n;
            WB_DATA     <= wb_data_n;
            MISALIGN    <= mis_n;
            if (lat_en) begin
                lat_size     <= sz_c;
                lat_uns      <= EX_FUNCT3[2];
                lat_off      <= EX_ADDR[1:0];
                lat_waddr    <= EX_ADDR[ADDR_W+1:2];
                lat_wdata    <= EX_WDATA;
                lat_rd       <= EX_RD;
                lat_regwrite <= EX_REGWRITE;
            end
        end
    end

endmodule
